// File: rtl/fifo_pkg.sv
// Shared FIFO geometry: depth, pointer width and occupancy-counter width.
package fifo_pkg;
  localparam int FIFO_DEPTH = 64;
  localparam int FIFO_AW    = 6;
  localparam int FIFO_CW    = 7;
endpackage

// File: rtl/dpram.sv
// 64x1 distributed dual-port RAM cell: synchronous write, asynchronous read.
module dpram
  import fifo_pkg::*;
(
  input  logic               WCLK,
  input  logic               we,
  input  logic [FIFO_AW-1:0] wa,
  input  logic [FIFO_AW-1:0] ra,
  input  logic               d,
  output logic               dpo
);

  logic [FIFO_DEPTH-1:0] mem_q;
  logic [FIFO_DEPTH-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wa] = d;
  end

  // Storage is deliberately not reset, matching LUT-RAM behaviour.
  always_ff @(posedge WCLK) begin
    mem_q <= mem_d;
  end

  assign dpo = mem_q[ra];

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO bookkeeping: write/read pointers, occupancy count, handshakes and level flags.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int AF_LEVEL = 56,
  parameter int AE_LEVEL = 8
) (
  input  logic               CLK,
  input  logic               Reset_n,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               out_ready,
  output logic               wr_en,
  output logic [FIFO_AW-1:0] wr_ptr,
  output logic [FIFO_AW-1:0] rd_ptr,
  output logic [FIFO_CW-1:0] count,
  output logic               in_ready,
  output logic               out_valid,
  output logic               almost_full,
  output logic               almost_empty
);

  localparam logic [FIFO_CW-1:0] FULL_CNT = FIFO_CW'(FIFO_DEPTH);
  localparam logic [FIFO_CW-1:0] AF_CNT   = FIFO_CW'(AF_LEVEL);
  localparam logic [FIFO_CW-1:0] AE_CNT   = FIFO_CW'(AE_LEVEL);

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CW-1:0] count_q, count_d;
  logic               push, pop;

  // Full/empty come from the count alone; pointers are free-running modulo 64.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_ready & out_valid;
  assign wr_en     = push & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      if (push && !pop)      count_d = count_q + FIFO_CW'(1);
      else if (pop && !push) count_d = count_q - FIFO_CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr       = wr_ptr_q;
  assign rd_ptr       = rd_ptr_q;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// 64-entry first-word-fall-through FIFO built from WIDTH parallel 64x1 dpram cells.
module dpram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int AF_LEVEL = 56,
  parameter int AE_LEVEL = 8
) (
  input  logic               CLK,
  input  logic               Reset_n,
  input  logic               flush,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIFO_CW-1:0] count,
  output logic               almost_full,
  output logic               almost_empty
);

  logic               wr_en;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;

  fifo_ptr_ctrl #(
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ptr_ctrl (
    .CLK          (CLK),
    .Reset_n      (Reset_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .out_ready    (out_ready),
    .wr_en        (wr_en),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    dpram u_cell (
      .WCLK (CLK),
      .we   (wr_en),
      .wa   (wr_ptr),
      .ra   (rd_ptr),
      .d    (in_data[i]),
      .dpo  (out_data[i])
    );
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed + randomized bench for dpram_fifo_ctrl against a queue-based FIFO model.
module tb_dpram_fifo_ctrl;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        flush;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  count;
  logic        almost_full;
  logic        almost_empty;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q[$];

  dpram_fifo_ctrl #(.WIDTH(32), .AF_LEVEL(56), .AE_LEVEL(8)) dut (
    .CLK          (CLK),
    .Reset_n      (Reset_n),
    .flush        (flush),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int sz;
    sz = q.size();
    chk("count", 32'(count), 32'(sz));
    chk("in_ready", 32'(in_ready), 32'(sz < 64));
    chk("out_valid", 32'(out_valid), 32'(sz > 0));
    chk("almost_full", 32'(almost_full), 32'(sz >= 56));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= 8));
    if (sz > 0) chk("out_data", out_data, q[0]);
  endtask

  // One clock: drive at negedge, check registered outputs, then advance the model at posedge.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    bit exp_push, exp_pop;
    @(negedge CLK);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1 check_model();
    exp_push = iv && (q.size() < 64);
    exp_pop  = ordy && (q.size() > 0);
    @(posedge CLK);
    if (fl) q.delete();
    else begin
      if (exp_pop) void'(q.pop_front());
      if (exp_push) q.push_back(d);
    end
  endtask

  initial begin
    int pushed;
    int cyc;
    logic iv, ordy;
    logic [31:0] d;

    Reset_n = 1'b0; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    Reset_n = 1'b1;

    // Reset asserted in the middle of a burst
    for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    #2 Reset_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    q.delete();
    @(negedge CLK);
    Reset_n = 1'b1;

    // Fill completely, then drain in order
    for (int k = 0; k < 64; k++) step(1'b1, 32'h11111111 + 32'(k) * 32'h01010101, 1'b0, 1'b0);
    #1;
    chk("fill_count", 32'(count), 32'd64);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_almost_full", 32'(almost_full), 32'd1);
    step(1'b1, 32'hBAD0BAD0, 1'b0, 1'b0);
    for (int k = 0; k < 64; k++) step(1'b0, '0, 1'b1, 1'b0);
    #1 chk("drain_count", 32'(count), 32'd0);

    // Random valid/ready gaps, pointers wrap several times
    pushed = 0;
    cyc = 0;
    while ((pushed < 200 || q.size() > 0) && cyc < 3000) begin
      iv   = (pushed < 200) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      d    = $urandom;
      if (iv && q.size() < 64) pushed++;
      step(iv, d, ordy, 1'b0);
      cyc++;
    end
    #1 chk("wrap_drained", 32'(count), 32'd0);

    // Full with simultaneous valid/ready: pop only, then push accepted
    for (int k = 0; k < 64; k++) step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, 32'h0F0F0F0F, 1'b1, 1'b0);
    #1 chk("full_pop_only", 32'(count), 32'd63);
    step(1'b1, 32'h5A5A5A5A, 1'b0, 1'b0);
    #1 chk("full_refill", 32'(count), 32'd64);
    for (int k = 0; k < 64; k++) step(1'b0, '0, 1'b1, 1'b0);

    // Empty with push and ready: visible only after the edge
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    #1;
    chk("fwft_valid", 32'(out_valid), 32'd1);
    chk("fwft_data", out_data, 32'hDEADBEEF);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush beats a simultaneous push and pop
    for (int k = 0; k < 10; k++) step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, 32'hCAFEF00D, 1'b1, 1'b1);
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) step(1'b1, 32'h70000000 + 32'(k), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
